register_file_multi_port: RTL

// - Parametrised register file for the RV32I core: N registered read ports, 1 write port.
// - Holds a per-register pending (scoreboard) bit: set at issue, cleared at writeback.
// - Sits between decode (read/claim) and writeback (write).
// - Generalises register_file_single_port in depth, width and read-port count.
//

---
 rtl/register_file_multi_port.sv | 98 +++++++++
 1 files changed

// File: rtl/register_file_multi_port.sv
// Multi-port register file with per-register pending (scoreboard) bits and registered reads.
// Optional macro REGFILE_BYPASS_EN: a same-edge write/claim is forwarded to a colliding read.
module register_file_multi_port #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int ZERO_REG     = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_we,
   input  logic [ADDR_WIDTH-1:0]                i_waddr,
   input  logic [DATA_WIDTH-1:0]                i_wdata,
   input  logic                                 i_claim,
   input  logic [ADDR_WIDTH-1:0]                i_claim_addr,
   input  logic [NUM_RD_PORTS-1:0]              i_re,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   i_raddr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   o_rdata,
   output logic [NUM_RD_PORTS-1:0]              o_rvalid,
   output logic [NUM_RD_PORTS-1:0]              o_rbusy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   function automatic logic is_zero_addr(input logic [ADDR_WIDTH-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   logic                  we_ok;
   logic                  claim_ok;
   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      pending;

   assign we_ok    = i_we    && !is_zero_addr(i_waddr);
   assign claim_ok = i_claim && !is_zero_addr(i_claim_addr);

   // Claim is applied after the write so a same-edge claim leaves the register pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pending <= '0;
      end else begin
         if (we_ok) begin
            regs[i_waddr]    <= i_wdata;
            pending[i_waddr] <= 1'b0;
         end
         if (claim_ok) pending[i_claim_addr] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr_p0;
      logic [DATA_WIDTH-1:0] data_p0;
      logic                  busy_p0;
      logic [DATA_WIDTH-1:0] data_p1;
      logic                  busy_p1;
      logic                  vld_p1;

      assign addr_p0 = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // p0: array lookup, optional same-edge forwarding
      always_comb begin
         data_p0 = regs[addr_p0];
         busy_p0 = pending[addr_p0];
`ifdef REGFILE_BYPASS_EN
         if (we_ok && (i_waddr == addr_p0)) begin
            data_p0 = i_wdata;
            busy_p0 = 1'b0;
         end
         if (claim_ok && (i_claim_addr == addr_p0)) busy_p0 = 1'b1;
`endif
         if (is_zero_addr(addr_p0)) begin
            data_p0 = '0;
            busy_p0 = 1'b0;
         end
      end

      // p1: registered read result; data and busy hold while the port is idle
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_p1 <= '0;
            busy_p1 <= 1'b0;
            vld_p1  <= 1'b0;
         end else begin
            vld_p1 <= i_re[k];
            if (i_re[k]) begin
               data_p1 <= data_p0;
               busy_p1 <= busy_p0;
            end
         end
      end

      assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = data_p1;
      assign o_rbusy[k]                          = busy_p1;
      assign o_rvalid[k]                         = vld_p1;
   end

endmodule
